branch_predictor: RTL

Fetch-side branch predictor. It consumes the resolved outcome that the execute-stage branch comparator produces (taken/not-taken plus target) and closes the loop back to instruction fetch. It holds a direct-mapped table of 2-bit saturating counters with a tagged branch target buffer (BTB), and answers fetch-stage lookups every cycle. When a resolved branch disagrees with its prediction, it raises a registered mispredict pulse and a redirect PC.

---
 rtl/branch_predictor.sv | 116 +++++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: 2-bit saturating direction counters plus a tagged BTB,
// trained by resolved branches from execute, with a registered mispredict/redirect back to fetch.
module branch_predictor #(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES),
  parameter  int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        btb_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       ctr_next;
  logic             mp_cond;

  // Lookup reads the registered table only, so an update in the same cycle is not seen.
  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[IDX_W+2 +: TAG_W];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? btb_q[lk_idx] : if_pc + 32'd4;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[IDX_W+2 +: TAG_W];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  assign mp_cond = upd_valid &&
                   ((upd_taken != upd_pred_taken) ||
                    (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    ctr_next = ctr_q[up_idx];
    if (upd_taken) begin
      if (ctr_q[up_idx] != CTR_STRONG_T) ctr_next = ctr_q[up_idx] + 2'd1;
    end else begin
      if (ctr_q[up_idx] != CTR_STRONG_NT) ctr_next = ctr_q[up_idx] - 2'd1;
    end
  end

  // NOTE: the table lives in flops, not RAM, so it can be cleared by the async reset;
  // state uses non-blocking assignments so all entries update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_WEAK_NT;
        tag_q[i] <= '0;
        btb_q[i] <= '0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_q[up_idx] <= ctr_next;
        if (upd_taken) btb_q[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Allocation overwrites whatever aliased branch held this slot.
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        btb_q[up_idx]   <= upd_target;
        ctr_q[up_idx]   <= CTR_WEAK_T;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mp_cond;
      if (mp_cond) redirect_pc <= upd_taken ? upd_target : upd_pc + 32'd4;
    end
  end

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (upd_valid && (br_count != '1))     br_count      <= br_count + 32'd1;
      if (mp_cond && (mispred_count != '1))  mispred_count <= mispred_count + 32'd1;
    end
  end

endmodule
